// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared defaults for the line buffer ring and its storage.
package line_buffer_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 9;
  localparam int NBL2_DEF = 1;
  localparam int UCW = 8;
endpackage

// File: rtl/lb_ram.sv
// lb_ram: simple dual-port RAM, synchronous read, no reset.
module lb_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          CLK_I,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always_ff @(posedge CLK_I) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/line_buffer_ring.sv
// line_buffer_ring: ring of line banks between a store side and a display fetch side.
module line_buffer_ring
  import line_buffer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NBL2 = NBL2_DEF
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [AW-1:0]   F_ADR_I,
  output logic [DW-1:0]   F_DAT_O,
  input  logic [AW-1:0]   S_ADR_I,
  input  logic [DW-1:0]   S_DAT_I,
  input  logic            S_WE_I,
  input  logic            S_DONE_I,
  input  logic            SWAP_I,
  input  logic            DOUBLE_I,
  output logic            FULL_O,
  output logic [NBL2-1:0] READY_O,
  output logic            UNDERRUN_O,
  output logic [UCW-1:0]  UCNT_O
);
  logic [NBL2-1:0] disp, rdy, fill;
  logic rep, f_vld, adv_try, adv, und, done, we;
  logic [DW-1:0] rd;
  assign fill = disp + rdy + NBL2'(1);
  assign FULL_O = &rdy;
  assign READY_O = rdy;
  assign done = S_DONE_I & ~FULL_O;
  assign adv_try = SWAP_I & (~DOUBLE_I | rep);
  assign adv = adv_try & |rdy;
  assign und = adv_try & ~|rdy;
  assign we = S_WE_I & ~FULL_O & ~RST_I;
  // RAM read register has no reset, so its output is masked until the first post-reset read
  assign F_DAT_O = f_vld ? rd : '0;
  lb_ram #(.DW(DW), .AW(AW + NBL2)) u_ram (
    .CLK_I(CLK_I),
    .we(we),
    .wa({fill, S_ADR_I}),
    .wd(S_DAT_I),
    .ra({disp, F_ADR_I}),
    .rd(rd)
  );
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      disp <= '0;
      rdy <= '0;
      rep <= 1'b0;
      f_vld <= 1'b0;
      UNDERRUN_O <= 1'b0;
      UCNT_O <= '0;
    end else begin
      disp <= disp + NBL2'(adv);
      rdy <= rdy + NBL2'(done) - NBL2'(adv);
      rep <= DOUBLE_I & (rep ^ SWAP_I);
      f_vld <= 1'b1;
      UNDERRUN_O <= und;
      UCNT_O <= UCNT_O + UCW'(und & ~&UCNT_O);
    end
  end
endmodule

// File: tb/tb_line_buffer_ring.sv
// tb_line_buffer_ring: directed checks on a 2-bank and a 4-bank ring sharing one stimulus.
module tb_line_buffer_ring;
  logic clk = 1'b0, rst = 1'b1;
  logic [8:0] f_adr = '0, s_adr = '0;
  logic [15:0] s_dat = '0;
  logic s_we = 1'b0, s_done = 1'b0, swap = 1'b0, dbl = 1'b0;
  logic [15:0] a_fdat, b_fdat;
  logic a_full, b_full, a_und, b_und;
  logic [0:0] a_ready;
  logic [1:0] b_ready;
  logic [7:0] a_ucnt, b_ucnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  line_buffer_ring ua (
    .CLK_I(clk), .RST_I(rst), .F_ADR_I(f_adr), .F_DAT_O(a_fdat), .S_ADR_I(s_adr),
    .S_DAT_I(s_dat), .S_WE_I(s_we), .S_DONE_I(s_done), .SWAP_I(swap), .DOUBLE_I(dbl),
    .FULL_O(a_full), .READY_O(a_ready), .UNDERRUN_O(a_und), .UCNT_O(a_ucnt)
  );
  line_buffer_ring #(.NBL2(2)) ub (
    .CLK_I(clk), .RST_I(rst), .F_ADR_I(f_adr), .F_DAT_O(b_fdat), .S_ADR_I(s_adr),
    .S_DAT_I(s_dat), .S_WE_I(s_we), .S_DONE_I(s_done), .SWAP_I(swap), .DOUBLE_I(dbl),
    .FULL_O(b_full), .READY_O(b_ready), .UNDERRUN_O(b_und), .UCNT_O(b_ucnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    s_we = 1'b1; s_adr = a; s_dat = d;
    cyc();
    s_we = 1'b0;
  endtask

  task automatic pulse(input logic do_done, input logic do_swap);
    s_done = do_done; swap = do_swap;
    cyc();
    s_done = 1'b0; swap = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_a_fdat", a_fdat, 0);
    chk("rst_a_full", a_full, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_und", a_und, 0);
    chk("rst_a_ucnt", a_ucnt, 0);
    chk("rst_b_full", b_full, 0);
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 512; i++) wr(9'(i), 16'hA000 + 16'(i));
    pulse(1, 0);
    chk("fill_a_ready", a_ready, 1);
    chk("fill_a_full", a_full, 1);
    chk("fill_b_ready", b_ready, 1);
    chk("fill_b_full", b_full, 0);
    pulse(0, 1);
    chk("swap_a_ready", a_ready, 0);
    chk("swap_a_und", a_und, 0);
    f_adr = 9'd5;
    cyc();
    chk("swap_a_fdat", a_fdat, 16'hA005);
    chk("swap_b_fdat", b_fdat, 16'hA005);
    pulse(0, 1);
    chk("ur_a_und", a_und, 1);
    chk("ur_a_ucnt", a_ucnt, 1);
    cyc();
    chk("ur_a_und_off", a_und, 0);
    chk("ur_a_repeat", a_fdat, 16'hA005);
    wr(9'd5, 16'hB005);
    pulse(1, 1);
    chk("du0_a_ready", a_ready, 1);
    chk("du0_a_und", a_und, 1);
    chk("du0_a_ucnt", a_ucnt, 2);
    chk("du0_b_ready", b_ready, 1);
    wr(9'd5, 16'hC005);
    pulse(1, 1);
    chk("du1_b_ready", b_ready, 1);
    chk("du1_b_und", b_und, 0);
    chk("du1_a_ready", a_ready, 0);
    cyc();
    chk("du1_b_fdat", b_fdat, 16'hB005);
    chk("du1_a_fdat", a_fdat, 16'hB005);
    wr(9'd5, 16'hD005); pulse(1, 0);
    wr(9'd5, 16'hE005); pulse(1, 0);
    chk("full_b_full", b_full, 1);
    chk("full_b_ready", b_ready, 3);
    wr(9'd5, 16'hDEAD); pulse(1, 0);
    chk("full_b_done_ign", b_ready, 3);
    cyc();
    chk("full_b_drop", b_fdat, 16'hB005);
    pulse(0, 1); cyc();
    chk("adv1_b_fdat", b_fdat, 16'hC005);
    chk("adv1_b_ready", b_ready, 2);
    pulse(0, 1); cyc();
    chk("adv2_b_fdat", b_fdat, 16'hD005);
    pulse(0, 1); cyc();
    chk("adv3_b_fdat", b_fdat, 16'hE005);
    chk("adv3_b_ready", b_ready, 0);
    chk("adv3_b_full", b_full, 0);
    chk("adv3_b_ucnt", b_ucnt, 2);
    chk("adv3_a_ucnt", a_ucnt, 4);
    chk("adv3_a_fdat", a_fdat, 16'hD005);
    wr(9'd5, 16'hF005); pulse(1, 0);
    wr(9'd5, 16'h1005); pulse(1, 0);
    chk("dbl_b_ready0", b_ready, 2);
    dbl = 1'b1;
    pulse(0, 1);
    chk("dbl1_b_ready", b_ready, 2);
    chk("dbl1_b_und", b_und, 0);
    pulse(0, 1);
    chk("dbl2_b_ready", b_ready, 1);
    chk("dbl2_b_und", b_und, 0);
    cyc();
    chk("dbl2_b_fdat", b_fdat, 16'hF005);
    pulse(0, 1);
    chk("dbl3_b_ready", b_ready, 1);
    chk("dbl3_b_und", b_und, 0);
    pulse(0, 1);
    chk("dbl4_b_ready", b_ready, 0);
    chk("dbl4_b_und", b_und, 0);
    cyc();
    chk("dbl4_b_fdat", b_fdat, 16'h1005);
    dbl = 1'b0;
    cyc();
    for (int i = 0; i < 300; i++) begin
      pulse(0, 1);
      cyc();
    end
    chk("sat_b_ucnt", b_ucnt, 255);
    chk("sat_a_ucnt", a_ucnt, 255);
    s_we = 1'b1; s_adr = 9'd0; s_dat = 16'h7777;
    cyc();
    rst = 1'b1;
    #2;
    chk("arst_b_fdat", b_fdat, 0);
    chk("arst_b_ucnt", b_ucnt, 0);
    chk("arst_b_ready", b_ready, 0);
    chk("arst_b_full", b_full, 0);
    chk("arst_b_und", b_und, 0);
    chk("arst_a_ucnt", a_ucnt, 0);
    chk("arst_a_fdat", a_fdat, 0);
    s_we = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("mem_kept_b", b_fdat, 16'hD005);
    chk("mem_kept_a", a_fdat, 16'hF005);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_buffer_ring.md
LINE_BUFFER_RING -- requirements
Module: line_buffer_ring

Interface
- REQ-001 The block SHALL have parameter DW, default 16, meaning the data word width in bits.
- REQ-002 The block SHALL have parameter AW, default 9, meaning the word address width per bank, so each bank holds 2^AW words.
- REQ-003 The block SHALL have parameter NBL2, default 1, meaning log2 of the bank count, so NB = 2^NBL2 banks; NBL2 ≥ 1.
- REQ-004 The block SHALL have these ports:
  - CLK_I, input, 1 bit: the only clock; all state changes on its rising edge.
  - RST_I, input, 1 bit: asynchronous, active-high reset.
  - F_ADR_I, input, AW bits: fetch (display) word address.
  - F_DAT_O, output, DW bits: fetch data, registered.
  - S_ADR_I, input, AW bits: store word address.
  - S_DAT_I, input, DW bits: store data.
  - S_WE_I, input, 1 bit: store strobe.
  - S_DONE_I, input, 1 bit: one-cycle pulse meaning the fill bank is complete.
  - SWAP_I, input, 1 bit: one-cycle pulse at the display line boundary, from the CRTC.
  - DOUBLE_I, input, 1 bit: line-doubling mode.
  - FULL_O, output, 1 bit: no bank is free to fill.
  - READY_O, output, NBL2 bits: count of completed banks waiting for display.
  - UNDERRUN_O, output, 1 bit: one-cycle pulse when a display advance found no ready bank.
  - UCNT_O, output, 8 bits: saturating underrun count.

Function
- REQ-005 Storage SHALL be NB banks of 2^AW words of DW bits; word {bank, addr} is addressed as bank*2^AW + addr.
- REQ-006 The block SHALL keep the following state:
  - disp, NBL2 bits: the bank owned by display.
  - rdy, NBL2 bits: count of completed banks.
  - fill: the bank owned by the store side, equal to (disp + rdy + 1) mod NB.
- REQ-007 FULL_O SHALL equal (rdy == NB-1), and READY_O SHALL equal rdy.
- REQ-008 On S_WE_I=1 with FULL_O=0, S_DAT_I SHALL be written to {fill, S_ADR_I}; when FULL_O=1 the write SHALL be dropped.
- REQ-009 F_DAT_O SHALL present the word at {disp, F_ADR_I} exactly one clock after F_ADR_I is sampled, with disp also sampled at that edge.
- REQ-010 Because the fill bank never equals the display bank, simultaneous equal F_ADR_I and S_ADR_I SHALL need no arbitration.
- REQ-011 S_DONE_I=1 with FULL_O=0 SHALL increment rdy; S_DONE_I while FULL_O=1 SHALL be ignored.
- REQ-012 On an advance attempt with rdy > 0 (value before the edge), disp SHALL increment mod NB and rdy SHALL decrement.
- REQ-013 On an advance attempt with rdy == 0 (value before the edge), disp SHALL be held, so the last line repeats; UNDERRUN_O SHALL pulse for one cycle and UCNT_O SHALL increment, saturating at 255.
- REQ-014 When S_DONE_I is accepted and an advance succeeds in the same cycle, rdy SHALL be unchanged and disp SHALL advance.
- REQ-015 When S_DONE_I is accepted in the same cycle as an underrun attempt, rdy SHALL become 1 and the underrun SHALL still be reported.
- REQ-016 When DOUBLE_I=0, every SWAP_I SHALL be an advance attempt, and the rep flag SHALL be held at 0.
- REQ-017 When DOUBLE_I=1, each SWAP_I SHALL toggle rep, and only a SWAP_I arriving with rep==1 SHALL be an advance attempt; each line therefore displays twice.
- REQ-018 DOUBLE_I changes SHALL take effect at the next SWAP_I; deasserting DOUBLE_I SHALL clear rep on the following clock.
- REQ-019 With default parameters, the store side SHALL always write the bank not being displayed, giving one line of latency.

Reset
- REQ-020 While RST_I is high the block SHALL force:
  - disp=0, rdy=0, rep=0;
  - F_DAT_O=0, UNDERRUN_O=0, UCNT_O=0;
  - therefore FULL_O=(NB==1 ? 1 : 0), READY_O=0 and fill=1.
- REQ-021 Memory contents SHALL NOT be cleared by reset.
- REQ-022 Reset in the middle of a fill SHALL abandon that partial line.
- REQ-023 Writes SHALL be suppressed while RST_I is high.

Structure
- REQ-024 The default values of DW, AW and NBL2 and the UCNT_O width (8) SHALL be defined in a shared package, line_buffer_pkg.
- REQ-025 Storage SHALL be one sub-module, lb_ram: a simple dual-port RAM with a synchronous read port, a write port with write-enable, and no reset.
- REQ-026 Pointer, count, flag and counter logic SHALL reside in line_buffer_ring itself.

Verification
- REQ-027 Default parameters: write 0xA000+i to addresses 0..511, pulse S_DONE_I, then SWAP_I -> reading address 5 gives F_DAT_O=0xA005 one cycle later; disp=1, READY_O=0.
- REQ-028 NBL2=2: fill and complete 3 lines -> FULL_O=1, READY_O=3; a fourth write of 0xDEAD is dropped and a further S_DONE_I is ignored.
- REQ-029 SWAP_I with READY_O=0 -> UNDERRUN_O pulses once, UCNT_O=1, and F_DAT_O still returns the previous line's data.
- REQ-030 S_DONE_I and SWAP_I in the same cycle:
  - with READY_O=1 -> READY_O stays 1 and disp advances;
  - with READY_O=0 -> READY_O=1 and an underrun is reported.
- REQ-031 DOUBLE_I=1 with 4 SWAP_I pulses and 2 ready lines -> disp advances only on the 2nd and 4th pulses, with no underrun.
- REQ-032 Force 300 underruns -> UCNT_O=255; then assert RST_I asynchronously mid-line -> all outputs reach their reset values before the next clock edge.
